// File: rtl/audio_fx_pkg.sv
// Shared types and effect table for the audio effect feeder.
// Holds the effect and FSM state enums, per-effect tone parameters
// (half-period, sweep delta, length, noise flag) and the LFSR seed.
package audio_fx_pkg;

  localparam int unsigned HALF_W = 8;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned LFSR_W = 16;

  typedef enum logic [1:0] {
    FX_SHOT      = 2'd0,
    FX_UFO       = 2'd1,
    FX_EXPLOSION = 2'd2,
    FX_STEP      = 2'd3
  } fx_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Indexed by fx_e: SHOT, UFO, EXPLOSION, STEP.
  // EXPLOSION's half-period is only used when noise generation is compiled out.
  localparam logic [HALF_W-1:0]  FX_HALF  [4] = '{8'd8, 8'd24, 8'd60, 8'd48};
  localparam logic signed [7:0]  FX_SWEEP [4] = '{8'sd1, 8'sd0, 8'sd0, 8'sd0};
  localparam logic [LEN_W-1:0]   FX_LEN   [4] = '{12'd512, 12'd1024, 12'd768, 12'd128};
  localparam logic               FX_NOISE [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/audio_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing one step when step=1.
// Ports: clk, rst_n (async active-low, loads LFSR_SEED), step, q (state).
module audio_lfsr
  import audio_fx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic feedback;

  assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= LFSR_SEED;
    else if (step) q <= {q[LFSR_W-2:0], feedback};
  end

endmodule

// File: rtl/audio_fx_feeder.sv
// Sound-effect sample generator feeding an I2S transmitter one stereo word
// per frame. Effects play a square tone (optionally swept), then release by
// halving amplitude in steps before returning to silence.
// Optional feature: define AUDIO_NOISE_EN to make EXPLOSION an LFSR noise burst.
// Ports: Clock (SCLK), nReset (async active-low), Ready (frame-done strobe),
//        fx_valid/fx_sel (effect request), busy (effect active), Tx {left,right}.
module audio_fx_feeder
  import audio_fx_pkg::*;
#(
  parameter int unsigned       WIDTH          = 16,
  parameter logic [WIDTH-1:0]  AMPLITUDE      = 16'h2000,
  parameter int unsigned       SWEEP_FRAMES   = 16,
  parameter int unsigned       RELEASE_FRAMES = 256
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               Ready,
  input  logic               fx_valid,
  input  logic [1:0]         fx_sel,
  output logic               busy,
  output logic [2*WIDTH-1:0] Tx
);

  localparam int unsigned SW_W  = $clog2(SWEEP_FRAMES + 1);
  localparam int unsigned REL_W = $clog2(RELEASE_FRAMES + 1);

  state_e              state, state_n, cur_state;
  logic                ready_q, tick;
  logic                pend_vld, pend_vld_n;
  fx_e                 pend_sel, pend_sel_n, req_sel;
  logic                req;
  logic [HALF_W-1:0]   half, half_n, cur_half, ph_inc;
  logic signed [7:0]   sweep, sweep_n, cur_sweep;
  logic [LEN_W-1:0]    len, len_n, cur_len, len_dec;
  logic [HALF_W-1:0]   phase, phase_n, cur_phase;
  logic                pol, pol_n, cur_pol;
  logic [WIDTH-1:0]    amp, amp_n, cur_amp, sample;
  logic [SW_W-1:0]     sw_cnt, sw_cnt_n, cur_sw_cnt, sw_inc;
  logic [REL_W-1:0]    rel_cnt, rel_cnt_n, cur_rel_cnt, rel_inc;
  logic [2:0]          shifts, shifts_n, cur_shifts, sh_inc;
  logic signed [9:0]   sw_sum;
  logic [2*WIDTH-1:0]  tx_n;

  // Rising edge of Ready marks a new frame.
  assign tick = Ready & ~ready_q;

  // A request on the tick edge itself is honoured on that tick.
  assign req     = fx_valid | pend_vld;
  assign req_sel = fx_valid ? fx_e'(fx_sel) : pend_sel;

`ifdef AUDIO_NOISE_EN
  logic              noise, noise_n, cur_noise, lfsr_step;
  logic [LFSR_W-1:0] lfsr_q;

  assign lfsr_step = tick && (cur_state != ST_IDLE);

  audio_lfsr u_lfsr (
    .clk   (Clock),
    .rst_n (nReset),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );
`endif

  // Next-state and datapath: load on request, then advance one frame per tick.
  always_comb begin
    cur_state   = state;
    cur_half    = half;
    cur_sweep   = sweep;
    cur_len     = len;
    cur_phase   = phase;
    cur_pol     = pol;
    cur_amp     = amp;
    cur_sw_cnt  = sw_cnt;
    cur_rel_cnt = rel_cnt;
    cur_shifts  = shifts;
`ifdef AUDIO_NOISE_EN
    cur_noise   = noise;
`endif
    if (tick && req) begin
      cur_state   = ST_PLAY;
      cur_half    = FX_HALF[req_sel];
      cur_sweep   = FX_SWEEP[req_sel];
      cur_len     = FX_LEN[req_sel];
      cur_phase   = '0;
      cur_pol     = 1'b1;
      cur_amp     = AMPLITUDE;
      cur_sw_cnt  = '0;
      cur_rel_cnt = '0;
      cur_shifts  = '0;
`ifdef AUDIO_NOISE_EN
      cur_noise   = FX_NOISE[req_sel];
`endif
    end

    state_n    = cur_state;
    half_n     = cur_half;
    sweep_n    = cur_sweep;
    len_n      = cur_len;
    phase_n    = cur_phase;
    pol_n      = cur_pol;
    amp_n      = cur_amp;
    sw_cnt_n   = cur_sw_cnt;
    rel_cnt_n  = cur_rel_cnt;
    shifts_n   = cur_shifts;
`ifdef AUDIO_NOISE_EN
    noise_n    = cur_noise;
`endif
    pend_vld_n = pend_vld;
    pend_sel_n = pend_sel;
    tx_n       = Tx;
    ph_inc     = cur_phase + 8'd1;
    len_dec    = cur_len - 12'd1;
    sw_inc     = cur_sw_cnt + SW_W'(1);
    rel_inc    = cur_rel_cnt + REL_W'(1);
    sh_inc     = cur_shifts + 3'd1;
    sw_sum     = signed'({2'b00, cur_half}) + signed'({{2{cur_sweep[7]}}, cur_sweep});
    sample     = cur_pol ? cur_amp : (~cur_amp) + WIDTH'(1);
`ifdef AUDIO_NOISE_EN
    if (cur_noise) sample = lfsr_q[0] ? cur_amp : (~cur_amp) + WIDTH'(1);
`endif

    if (fx_valid) begin
      pend_vld_n = 1'b1;
      pend_sel_n = fx_e'(fx_sel);
    end

    if (tick) begin
      pend_vld_n = 1'b0;
      if (cur_state == ST_IDLE) begin
        tx_n = '0;
      end else begin
        tx_n = {sample, sample};
        // Square-wave phase runs in both PLAY and RELEASE.
        if (ph_inc == cur_half) begin
          pol_n   = ~cur_pol;
          phase_n = '0;
        end else begin
          phase_n = ph_inc;
        end

        if (cur_state == ST_PLAY) begin
          // Half-period sweep, saturated to 1..255.
          if (sw_inc == SW_W'(SWEEP_FRAMES)) begin
            sw_cnt_n = '0;
            if (sw_sum < 10'sd1)        half_n = 8'd1;
            else if (sw_sum > 10'sd255) half_n = 8'd255;
            else                        half_n = sw_sum[7:0];
          end else begin
            sw_cnt_n = sw_inc;
          end
          len_n = len_dec;
          if (len_dec == '0) state_n = ST_RELEASE;
        end else begin
          // Release: halve amplitude every RELEASE_FRAMES ticks, four times.
          if (rel_inc == REL_W'(RELEASE_FRAMES)) begin
            rel_cnt_n = '0;
            amp_n     = cur_amp >> 1;
            shifts_n  = sh_inc;
            if (sh_inc == 3'd4) state_n = ST_IDLE;
          end else begin
            rel_cnt_n = rel_inc;
          end
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      pend_vld <= 1'b0;
      pend_sel <= FX_SHOT;
      half     <= '0;
      sweep    <= '0;
      len      <= '0;
      phase    <= '0;
      pol      <= 1'b1;
      amp      <= AMPLITUDE;
      sw_cnt   <= '0;
      rel_cnt  <= '0;
      shifts   <= '0;
      Tx       <= '0;
      busy     <= 1'b0;
`ifdef AUDIO_NOISE_EN
      noise    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      ready_q  <= Ready;
      pend_vld <= pend_vld_n;
      pend_sel <= pend_sel_n;
      half     <= half_n;
      sweep    <= sweep_n;
      len      <= len_n;
      phase    <= phase_n;
      pol      <= pol_n;
      amp      <= amp_n;
      sw_cnt   <= sw_cnt_n;
      rel_cnt  <= rel_cnt_n;
      shifts   <= shifts_n;
      Tx       <= tx_n;
      busy     <= (state_n != ST_IDLE);
`ifdef AUDIO_NOISE_EN
      noise    <= noise_n;
`endif
    end
  end

endmodule

// File: tb/tb_audio_fx_feeder.sv
// Directed bench for audio_fx_feeder with an expected-sample queue.
module tb_audio_fx_feeder;

  logic        Clock;
  logic        nReset;
  logic        Ready;
  logic        fx_valid;
  logic [1:0]  fx_sel;
  logic        busy;
  logic [31:0] Tx;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  audio_fx_feeder #(
    .WIDTH          (16),
    .AMPLITUDE      (16'h2000),
    .SWEEP_FRAMES   (16),
    .RELEASE_FRAMES (4)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Ready    (Ready),
    .fx_valid (fx_valid),
    .fx_sel   (fx_sel),
    .busy     (busy),
    .Tx       (Tx)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] smp(input bit pos, input logic [15:0] a);
    logic [15:0] s;
    s = pos ? a : (~a + 16'd1);
    return {s, s};
  endfunction

  // One frame: Ready low for an edge, then high; fx_valid optionally on the rising edge.
  task automatic pulse(input logic v, input logic [1:0] s);
    @(negedge Clock); Ready = 1'b0; fx_valid = 1'b0;
    @(negedge Clock); Ready = 1'b1; fx_valid = v; fx_sel = s;
    @(posedge Clock); #1; fx_valid = 1'b0;
  endtask

  task automatic request(input logic [1:0] s);
    @(negedge Clock); fx_valid = 1'b1; fx_sel = s;
    @(negedge Clock); fx_valid = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge Clock); Ready = 1'b0; fx_valid = 1'b0; nReset = 1'b0;
    @(negedge Clock); nReset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    #12;
    total++; if (Tx !== 32'h0) begin bad++; $display("FAIL reset_tx: got %h want 00000000", Tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge Clock); nReset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(32'h0);
      pulse(1'b0, 2'd0);
      e = exp_q.pop_front();
      total++; if (Tx !== e) begin bad++; $display("FAIL idle_tx tick %0d: got %h want %h", i, Tx, e); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy tick %0d: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_step();
    logic [31:0] e;
    logic [15:0] a;
    bit pos;
    hard_reset();
    request(2'd3);
    for (int i = 1; i <= 145; i++) begin
      pos = (((i - 1) / 48) % 2) == 0;
      a   = (i <= 128) ? 16'h2000 : (16'h2000 >> ((i - 129) / 4));
      exp_q.push_back((i == 145) ? 32'h0 : smp(pos, a));
      pulse(1'b0, 2'd0);
      e = exp_q.pop_front();
      total++; if (Tx !== e) begin bad++; $display("FAIL step_tx tick %0d: got %h want %h", i, Tx, e); end
      total++; if (busy !== (i < 144)) begin bad++; $display("FAIL step_busy tick %0d: got %b want %b", i, busy, (i < 144)); end
      if (i == 5) begin
        // Ready still high: no new frame, Tx must hold.
        @(posedge Clock); #1;
        total++; if (Tx !== 32'h20002000) begin bad++; $display("FAIL step_hold: got %h want 20002000", Tx); end
      end
    end
  endtask

  task automatic test_shot();
    logic [31:0] e;
    bit pos;
    hard_reset();
    request(2'd0);
    for (int i = 1; i <= 34; i++) begin
      pos = (i <= 8) || (i >= 17 && i <= 25);
      exp_q.push_back(smp(pos, 16'h2000));
      pulse(1'b0, 2'd0);
      e = exp_q.pop_front();
      total++; if (Tx !== e) begin bad++; $display("FAIL shot_tx tick %0d: got %h want %h", i, Tx, e); end
    end
  endtask

  task automatic test_overwrite();
    logic [31:0] e;
    hard_reset();
    request(2'd0);
    request(2'd3);
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(32'h20002000);
      pulse(1'b0, 2'd0);
      e = exp_q.pop_front();
      total++; if (Tx !== e) begin bad++; $display("FAIL overwrite_tx tick %0d: got %h want %h", i, Tx, e); end
    end
  endtask

  task automatic test_preempt();
    logic [31:0] e;
    hard_reset();
    request(2'd1);
    for (int i = 1; i <= 30; i++) begin
      exp_q.push_back(smp(i <= 24, 16'h2000));
      pulse(1'b0, 2'd0);
      e = exp_q.pop_front();
      total++; if (Tx !== e) begin bad++; $display("FAIL ufo_tx tick %0d: got %h want %h", i, Tx, e); end
    end
    request(2'd3);
    for (int k = 1; k <= 49; k++) begin
      exp_q.push_back(smp(k <= 48, 16'h2000));
      pulse(1'b0, 2'd0);
      e = exp_q.pop_front();
      total++; if (Tx !== e) begin bad++; $display("FAIL preempt_tx tick %0d: got %h want %h", k, Tx, e); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL preempt_busy tick %0d: got %b want 1", k, busy); end
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] e;
    hard_reset();
    exp_q.push_back(32'h0);
    pulse(1'b0, 2'd0);
    e = exp_q.pop_front();
    total++; if (Tx !== e) begin bad++; $display("FAIL same_edge_pre: got %h want %h", Tx, e); end
    exp_q.push_back(32'h20002000);
    pulse(1'b1, 2'd3);
    e = exp_q.pop_front();
    total++; if (Tx !== e) begin bad++; $display("FAIL same_edge_first: got %h want %h", Tx, e); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL same_edge_busy: got %b want 1", busy); end
    exp_q.push_back(32'h20002000);
    pulse(1'b0, 2'd0);
    e = exp_q.pop_front();
    total++; if (Tx !== e) begin bad++; $display("FAIL same_edge_second: got %h want %h", Tx, e); end
  endtask

  task automatic test_release_reset();
    logic [31:0] e;
    hard_reset();
    request(2'd3);
    for (int i = 1; i <= 130; i++) pulse(1'b0, 2'd0);
    total++; if (Tx !== 32'h20002000) begin bad++; $display("FAIL rel_sample: got %h want 20002000", Tx); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rel_busy: got %b want 1", busy); end
    #2; nReset = 1'b0; #1;
    total++; if (Tx !== 32'h0) begin bad++; $display("FAIL rel_reset_tx: got %h want 00000000", Tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_reset_busy: got %b want 0", busy); end
    @(negedge Clock); nReset = 1'b1;
    exp_q.push_back(32'h0);
    pulse(1'b0, 2'd0);
    e = exp_q.pop_front();
    total++; if (Tx !== e) begin bad++; $display("FAIL rel_after_tx: got %h want %h", Tx, e); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_after_busy: got %b want 0", busy); end
  endtask

`ifndef AUDIO_NOISE_EN
  task automatic test_explosion();
    logic [31:0] e;
    hard_reset();
    request(2'd2);
    for (int i = 1; i <= 62; i++) begin
      exp_q.push_back(smp(i <= 60, 16'h2000));
      pulse(1'b0, 2'd0);
      e = exp_q.pop_front();
      total++; if (Tx !== e) begin bad++; $display("FAIL explosion_tx tick %0d: got %h want %h", i, Tx, e); end
    end
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    nReset   = 1'b0;
    Ready    = 1'b0;
    fx_valid = 1'b0;
    fx_sel   = 2'd0;
    test_reset();
    test_step();
    test_shot();
    test_overwrite();
    test_preempt();
    test_same_edge();
    test_release_reset();
`ifndef AUDIO_NOISE_EN
    test_explosion();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
